// File: rtl/qvalue_scanner.sv
// qvalue_scanner: memory-side initiator that walks a table of 16-bit
// big-endian words, tracks the largest entry and its index, and optionally
// writes {best_value, best_index} back to a destination address.
//
// Build option: define QSCAN_WRITEBACK_EN to include the WR_VAL/WR_IDX
// write-back states. Without it the scanner never writes, mem_wr_en and
// mem_wdata stay 0, and dest_addr is ignored.
//
// Memory read port is combinational: the word addressed in a SCAN cycle is
// valid on mem_rdata in that same cycle and is sampled on its closing edge.
module qvalue_scanner #(
  parameter int MAX_ENTRIES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [6:0]  count,
  input  logic [15:0] dest_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] best_value,
  output logic [5:0]  best_index,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [6:0] MAX_COUNT = 7'(MAX_ENTRIES);

`ifdef QSCAN_WRITEBACK_EN
  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WR_VAL,
    WR_IDX,
    DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [6:0]  count_q, count_d;
  logic [6:0]  idx_q, idx_d;
  logic [15:0] best_value_q, best_value_d;
  logic [5:0]  best_index_q, best_index_d;

  logic [6:0]  count_clamped;
  logic [15:0] scan_addr;

`ifdef QSCAN_WRITEBACK_EN
  logic [15:0] dest_q, dest_d;
`else
  // dest_addr has no consumer when write-back is compiled out.
  logic unused_dest_addr;
  assign unused_dest_addr = ^dest_addr;
`endif

  // Requested length limited to the largest supported table.
  assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;

  // Entry address: base + 2*i, wrapping naturally at 16 bits.
  assign scan_addr = base_q + {8'd0, idx_q, 1'b0};

  // Next-state logic and memory-port drive for the current state.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    base_d       = base_q;
    count_d      = count_q;
    idx_d        = idx_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
`ifdef QSCAN_WRITEBACK_EN
    dest_d       = dest_q;
`endif
    mem_address  = 16'd0;
    mem_wr_en    = 1'b0;
    mem_wdata    = 16'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d       = base_addr;
          count_d      = count_clamped;
          idx_d        = 7'd0;
          // Results restart from zero so an empty scan reports 0/0.
          best_value_d = 16'd0;
          best_index_d = 6'd0;
`ifdef QSCAN_WRITEBACK_EN
          dest_d       = dest_addr;
`endif
          state_d      = (count_clamped == 7'd0) ? DONE : SCAN;
        end
      end

      SCAN: begin
        mem_address = scan_addr;
        // First entry seeds the result; later ones must be strictly
        // greater, so ties keep the lowest index.
        if ((idx_q == 7'd0) || (mem_rdata > best_value_q)) begin
          best_value_d = mem_rdata;
          best_index_d = idx_q[5:0];
        end
        idx_d = idx_q + 7'd1;
        if (idx_q == (count_q - 7'd1)) begin
`ifdef QSCAN_WRITEBACK_EN
          state_d = WR_VAL;
`else
          state_d = DONE;
`endif
        end
      end

`ifdef QSCAN_WRITEBACK_EN
      WR_VAL: begin
        mem_address = dest_q;
        mem_wr_en   = 1'b1;
        mem_wdata   = best_value_q;
        state_d     = WR_IDX;
      end

      WR_IDX: begin
        mem_address = dest_q + 16'd2;
        mem_wr_en   = 1'b1;
        mem_wdata   = {10'd0, best_index_q};
        state_d     = DONE;
      end
`endif

      DONE: begin
        // start is deliberately not looked at here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q      <= IDLE;
      base_q       <= 16'd0;
      count_q      <= 7'd0;
      idx_q        <= 7'd0;
      best_value_q <= 16'd0;
      best_index_q <= 6'd0;
`ifdef QSCAN_WRITEBACK_EN
      dest_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
`ifdef QSCAN_WRITEBACK_EN
      dest_q       <= dest_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign best_value = best_value_q;
  assign best_index = best_index_q;

endmodule

// File: tb/tb_qvalue_scanner.sv
// Self-checking bench for qvalue_scanner: byte-addressed big-endian memory
// model with a combinational read port, a reference model that recomputes
// the maximum from memory contents, and scenario tasks for the scan flows.
`timescale 1ns/1ps
module tb_qvalue_scanner;

`ifdef QSCAN_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam int MAX_ENTRIES = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [6:0]  count = 7'd0;
  logic [15:0] dest_addr = 16'd0;
  logic        busy, done;
  logic [15:0] best_value;
  logic [5:0]  best_index;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [7:0]  mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = 16'd0;
  logic [15:0] tb_data = 16'd0;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_pulses = 0;
  int done_pulses = 0;

  qvalue_scanner #(.MAX_ENTRIES(MAX_ENTRIES)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .dest_addr  (dest_addr),
    .busy       (busy),
    .done       (done),
    .best_value (best_value),
    .best_index (best_index),
    .mem_address(mem_address),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Combinational big-endian read.
  assign mem_rdata = {mem[mem_address], mem[mem_address + 16'd1]};

  // Single writer for the memory (bench backdoor or DUT) plus event counters.
  always @(posedge clock) begin
    if (tb_we) begin
      mem[tb_addr]         <= tb_data[15:8];
      mem[tb_addr + 16'd1] <= tb_data[7:0];
    end else if (mem_wr_en) begin
      mem[mem_address]         <= mem_wdata[15:8];
      mem[mem_address + 16'd1] <= mem_wdata[7:0];
    end
    if (mem_wr_en) wr_pulses <= wr_pulses + 1;
    if (done) done_pulses <= done_pulses + 1;
  end

  function automatic logic [15:0] read_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], mem[a1]};
  endfunction

  task automatic write_word(input logic [15:0] a, input logic [15:0] v);
    @(negedge clock);
    tb_we = 1'b1; tb_addr = a; tb_data = v;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  // Reference: maximum over the first n words, lowest index on ties.
  function automatic void model(input logic [15:0] b, input int n,
                                output logic [15:0] bv, output logic [5:0] bi);
    logic [15:0] v;
    bv = 16'd0; bi = 6'd0;
    for (int i = 0; i < n; i++) begin
      v = read_word(b + 16'(2 * i));
      if (i == 0 || v > bv) begin
        bv = v; bi = 6'(i);
      end
    end
  endfunction

  // Starts one scan and observes it up to one cycle past done.
  // repulse: cycle offset (from k) at which start is raised again for one cycle.
  task automatic do_scan(input logic [15:0] b, input logic [6:0] c, input logic [15:0] d,
                         input int repulse, output int lat, output int scan_cyc,
                         output int wr_n, output int done_n, output logic [15:0] bv_done,
                         output logic [5:0] bi_done, output logic [15:0] addr_done,
                         output bit timed_out);
    int wr0, dn0;
    wr0 = wr_pulses; dn0 = done_pulses;
    @(negedge clock);
    base_addr = b; count = c; dest_addr = d; start = 1'b1;
    @(negedge clock);
    lat = 1; scan_cyc = 0;
    start = (repulse == 1);
    while (!done && lat < 300) begin
      if (busy && !mem_wr_en) scan_cyc++;
      @(negedge clock);
      lat++;
      start = (lat == repulse);
    end
    timed_out = !done;
    bv_done = best_value; bi_done = best_index; addr_done = mem_address;
    @(negedge clock);
    start = 1'b0;
    wr_n = wr_pulses - wr0; done_n = done_pulses - dn0;
  endtask

  task automatic test_scan_case(input string name, input logic [15:0] b, input logic [6:0] c,
                                input logic [15:0] d, input int repulse);
    int n, exp_lat, exp_wr, lat, scan_cyc, wr_n, done_n;
    logic [15:0] ev, pre_v, pre_i, exp_v, exp_i, bv_done, addr_done, got_v, got_i;
    logic [5:0]  ei, bi_done;
    bit timed_out;
    n = (int'(c) > MAX_ENTRIES) ? MAX_ENTRIES : int'(c);
    model(b, n, ev, ei);
    exp_lat = (n == 0) ? 1 : n + (WB ? 3 : 1);
    exp_wr  = (WB && n > 0) ? 2 : 0;
    pre_v = read_word(d);
    pre_i = read_word(d + 16'd2);
    exp_v = (WB && n > 0) ? ev : pre_v;
    exp_i = (WB && n > 0) ? {10'd0, ei} : pre_i;
    do_scan(b, c, d, repulse, lat, scan_cyc, wr_n, done_n, bv_done, bi_done, addr_done, timed_out);
    got_v = read_word(d);
    got_i = read_word(d + 16'd2);

    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL %s timeout: no done within %0d cycles", name, lat); end
    tests_run++;
    if (lat !== exp_lat) begin tests_failed++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
    tests_run++;
    if (scan_cyc !== n) begin tests_failed++; $display("FAIL %s scan_cycles: got %0d expected %0d", name, scan_cyc, n); end
    tests_run++;
    if (bv_done !== ev) begin tests_failed++; $display("FAIL %s best_value: got %h expected %h", name, bv_done, ev); end
    tests_run++;
    if (bi_done !== ei) begin tests_failed++; $display("FAIL %s best_index: got %0d expected %0d", name, bi_done, ei); end
    tests_run++;
    if (addr_done !== 16'd0) begin tests_failed++; $display("FAIL %s done_address: got %h expected 0000", name, addr_done); end
    tests_run++;
    if (best_value !== ev || best_index !== ei) begin
      tests_failed++;
      $display("FAIL %s hold: got %h/%0d expected %h/%0d", name, best_value, best_index, ev, ei);
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL %s busy_after_done: got %b expected 0", name, busy); end
    tests_run++;
    if (done_n !== 1) begin tests_failed++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_n); end
    tests_run++;
    if (wr_n !== exp_wr) begin tests_failed++; $display("FAIL %s write_pulses: got %0d expected %0d", name, wr_n, exp_wr); end
    tests_run++;
    if (got_v !== exp_v) begin tests_failed++; $display("FAIL %s mem_dest: got %h expected %h", name, got_v, exp_v); end
    tests_run++;
    if (got_i !== exp_i) begin tests_failed++; $display("FAIL %s mem_dest2: got %h expected %h", name, got_i, exp_i); end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy=%b done=%b wr=%b expected 0 0 0", busy, done, mem_wr_en);
    end
    tests_run++;
    if (best_value !== 16'd0 || best_index !== 6'd0 || mem_address !== 16'd0 || mem_wdata !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %0d %h %h expected all 0", best_value, best_index, mem_address, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_qvalue;
    for (int i = 0; i < 16; i++) write_word(16'h01C8 + 16'(2 * i), 16'(16 - i));
    test_scan_case("qvalue", 16'h01C8, 7'd16, 16'h0710, 0);
  endtask

  task automatic test_neighbor;
    for (int i = 0; i < 16; i++) write_word(16'h0048 + 16'(2 * i), 16'(i));
    test_scan_case("neighbor", 16'h0048, 7'd16, 16'h0700, 0);
  endtask

  task automatic test_tie;
    for (int i = 0; i < 16; i++) write_word(16'h2000 + 16'(2 * i), 16'($urandom_range(0, 254)));
    write_word(16'h2006, 16'h00FF);
    write_word(16'h2012, 16'h00FF);
    test_scan_case("tie", 16'h2000, 7'd16, 16'h0720, 0);
  endtask

  task automatic test_count_zero;
    test_scan_case("count_zero", 16'h0048, 7'd0, 16'h0730, 0);
  endtask

  task automatic test_clamp;
    for (int i = 0; i < 100; i++)
      write_word(16'h4000 + 16'(2 * i), (i < 64) ? 16'($urandom_range(0, 32767)) : 16'hFFFF);
    test_scan_case("clamp", 16'h4000, 7'd100, 16'h0740, 0);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) write_word(16'hFFF8 + 16'(2 * i), 16'($urandom));
    write_word(16'h0002, 16'hFFFE);
    test_scan_case("wrap", 16'hFFF8, 7'd8, 16'h0750, 0);
  endtask

  task automatic test_random;
    logic [15:0] b;
    int c;
    for (int it = 0; it < 8; it++) begin
      b = 16'($urandom_range(32'h1000, 32'h5000));
      b[0] = 1'b0;
      c = $urandom_range(1, 80);
      for (int i = 0; i < c; i++)
        write_word(b + 16'(2 * i), (it % 2 == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom));
      test_scan_case("random", b, 7'(c), 16'h9000 + 16'(4 * it), 0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) write_word(16'h5000 + 16'(2 * i), 16'($urandom));
    // Re-pulse in SCAN, then in the DONE cycle; both must be ignored.
    test_scan_case("repulse_scan", 16'h5000, 7'd10, 16'h0760, 3);
    test_scan_case("repulse_done", 16'h5000, 7'd10, 16'h0770, WB ? 13 : 11);
  endtask

  task automatic test_reset_mid;
    int wr0, dn0;
    for (int i = 0; i < 16; i++) write_word(16'h3000 + 16'(2 * i), 16'($urandom_range(1, 65535)));
    write_word(16'h0780, 16'hA5A5);
    write_word(16'h0782, 16'h5A5A);
    wr0 = wr_pulses; dn0 = done_pulses;
    @(negedge clock);
    base_addr = 16'h3000; count = 7'd16; dest_addr = 16'h0780; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_wr_en !== 1'b0 || mem_address !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: got busy=%b done=%b wr=%b addr=%h expected 0 0 0 0000",
               busy, done, mem_wr_en, mem_address);
    end
    tests_run++;
    if (best_value !== 16'd0 || best_index !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_best: got %h/%0d expected 0000/0", best_value, best_index);
    end
    repeat (20) @(negedge clock);
    tests_run++;
    if (wr_pulses !== wr0 || done_pulses !== dn0) begin
      tests_failed++;
      $display("FAIL reset_mid_events: got wr=%0d done=%0d expected 0 0", wr_pulses - wr0, done_pulses - dn0);
    end
    tests_run++;
    if (read_word(16'h0780) !== 16'hA5A5 || read_word(16'h0782) !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL reset_mid_mem: got %h %h expected a5a5 5a5a", read_word(16'h0780), read_word(16'h0782));
    end
    test_scan_case("after_reset", 16'h3000, 7'd16, 16'h0780, 0);
  endtask

  initial begin
    test_reset();
    test_qvalue();
    test_neighbor();
    test_tie();
    test_count_zero();
    test_clamp();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
